btn_sw_conditioner: RTL
=======================

// Module: btn_sw_conditioner
// PURPOSE
//  Input front end of the black-and-white game board: turns raw buttons and slide switches into clean signals.
//  Synchronises, debounces and edge-detects btnCenter/Top/Bottom/Left/Right, and gives at most one press pulse per cycle.
//  Produces debounced switches plus a validated one-hot card selection (sw[8:0]) for the game FSM and handout logic.
// PARAMETERS
//  DEBOUNCE_CYCLES  1000000  consecutive stable cycles before a button level changes (10 ms at 100 MHz); >=2
//  SW_DEBOUNCE      1000000  same rule for each switch bit; >=2
//  CNT_W            20       counter width; must hold max(DEBOUNCE_CYCLES,SW_DEBOUNCE)-1
// PORTS
//  clk          in   1   system clock
//  reset        in   1   synchronous, active-high reset
//  btn_raw      in   5   raw buttons: [4]=center [3]=top [2]=bottom [1]=left [0]=right
//  sw_raw       in   16  raw slide switches
//  btn_level    out  5   debounced button levels, same bit order
//  btn_pulse    out  5   one-cycle press pulse, at most one bit high per cycle
//  sw_stable    out  16  debounced switch levels
//  card_onehot  out  1   1 when sw_stable[8:0] has exactly one bit set
//  card_idx     out  4   index 0..8 of that set bit; 4'hF when card_onehot=0
// BEHAVIOUR
//  Reset (clk edge with reset=1): sync flops, counters, btn_level, btn_pulse, sw_stable, card_onehot <= 0; card_idx <= 4'hF.
//  Every bit of btn_raw and sw_raw goes through a 2-flop synchroniser (s1->s2). No raw input drives logic directly.
//  Per-bit debounce uses one counter and the stable level L:
//   - if s2==L: counter <= 0
//   - else if counter==N-1: L <= s2, counter <= 0 (N = DEBOUNCE_CYCLES or SW_DEBOUNCE)
//   - else counter <= counter+1
//   - A glitch shorter than N cycles at s2 never changes L. A raw change held steady shows on L exactly N+2 cycles after the raw edge.
//  Per-button press FSM: IDLE -(L rises)-> HELD -(L falls)-> IDLE.
//   - The IDLE->HELD transition requests a pulse. Release makes no pulse.
//   - btn_pulse is registered. It is high during the first cycle btn_level reads 1.
//  Arbitration when several requests occur in the same cycle:
//   - Fixed priority center > top > bottom > left > right. Only the winner pulses.
//   - Losers go to HELD with no pulse and are never replayed.
//  Holding a button gives one pulse. The next pulse needs a debounced release and then a new press.
//  card_onehot and card_idx are registered from sw_stable[8:0]. They update 1 cycle after sw_stable changes.
//   - Zero set bits or two or more set bits: card_onehot=0, card_idx=4'hF.
//  sw_stable[15:9] pass through the debounce only. No other decode.
//  Reset mid-operation:
//   - Asserting reset aborts every count, any pending pulse, and the FSM (back to IDLE).
//   - A button still held when reset deasserts is treated as a new press. It pulses N+2 cycles later (synchroniser refill + debounce).
//  Counters saturate at N-1 and never wrap. CNT_W overflow cannot occur under the parameter rule above.
// TESTING (DEBOUNCE_CYCLES=SW_DEBOUNCE=4)
//  1. reset=1 for 2 cycles, then btn_raw=0 -> all outputs 0, card_idx=4'hF, btn_pulse never high.
//  2. btn_raw[4] high at cycle 0 and held -> btn_level[4]=1 and btn_pulse=5'b10000 at cycle 6 only; btn_pulse=0 from cycle 7 on.
//  3. btn_raw[3] high for 3 cycles, then low -> btn_level[3] and btn_pulse stay 0.
//  4. btn_raw[4] and btn_raw[1] rise in the same cycle -> btn_pulse=5'b10000 once, btn_level=5'b10010, left never pulses; release left, press again -> 5'b00010.
//  5. sw_raw[8:0]=9'b000100000 -> card_onehot=1, card_idx=5 one cycle after sw_stable updates; sw_raw[8:0]=9'b000100001 -> card_onehot=0, card_idx=4'hF.
//  6. Hold btn_raw[2], assert reset for 1 cycle at cycle 10 -> outputs clear; btn_pulse[2] fires exactly 6 cycles after reset deasserts.

Source files
------------

// File: rtl/btn_sw_conditioner.sv
// btn_sw_conditioner
// Input front end for the game board. Every raw button and switch bit is
// synchronised and debounced. Buttons also get a press FSM with fixed-priority
// single-pulse arbitration. The low nine switches are decoded into a validated
// one-hot card selection.
module btn_sw_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int SW_DEBOUNCE     = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  btn_raw,
  input  logic [15:0] sw_raw,
  output logic [4:0]  btn_level,
  output logic [4:0]  btn_pulse,
  output logic [15:0] sw_stable,
  output logic        card_onehot,
  output logic [3:0]  card_idx
);

  localparam logic [CNT_W-1:0] BTN_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SW_LAST  = CNT_W'(SW_DEBOUNCE - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HELD = 1'b1;

  // Counter step that pins at the terminal count instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c,
                                               input logic [CNT_W-1:0] lim);
    return (c >= lim) ? lim : c + 1'b1;
  endfunction

  // Exactly-one-bit check with index; {valid, idx}, idx=F when not one-hot.
  function automatic logic [4:0] card_decode(input logic [8:0] s);
    logic [3:0]  idx;
    int unsigned n;
    idx = 4'hF;
    n   = 0;
    for (int i = 0; i < 9; i++) begin
      if (s[i]) begin
        n   = n + 1;
        idx = 4'(i);
      end
    end
    if (n == 1) return {1'b1, idx};
    return {1'b0, 4'hF};
  endfunction

  logic [4:0]       btn_sync_p0, btn_sync_p1;
  logic [15:0]      sw_sync_p0, sw_sync_p1;
  logic [CNT_W-1:0] btn_cnt [5];
  logic [CNT_W-1:0] sw_cnt [16];
  logic [4:0]       btn_rise, btn_fall, btn_req, btn_grant;
  logic [15:0]      sw_commit;
  logic [0:0]       btn_state [5];

  // Stage p0 -> p1: two-flop synchroniser for every raw input bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      btn_sync_p0 <= '0;
      btn_sync_p1 <= '0;
      sw_sync_p0  <= '0;
      sw_sync_p1  <= '0;
    end else begin
      btn_sync_p0 <= btn_raw;
      btn_sync_p1 <= btn_sync_p0;
      sw_sync_p0  <= sw_raw;
      sw_sync_p1  <= sw_sync_p0;
    end
  end

  // Level-change commit points: synchronised value disagrees and the count is full.
  always_comb begin
    btn_rise  = '0;
    btn_fall  = '0;
    sw_commit = '0;
    for (int i = 0; i < 5; i++) begin
      if ((btn_sync_p1[i] != btn_level[i]) && (btn_cnt[i] == BTN_LAST)) begin
        btn_rise[i] = btn_sync_p1[i];
        btn_fall[i] = ~btn_sync_p1[i];
      end
    end
    for (int i = 0; i < 16; i++) begin
      sw_commit[i] = (sw_sync_p1[i] != sw_stable[i]) && (sw_cnt[i] == SW_LAST);
    end
  end

  // Button debounce: count consecutive disagreeing cycles, adopt the new level at N.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 5; i++) btn_cnt[i] <= '0;
      btn_level <= '0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (btn_sync_p1[i] == btn_level[i]) begin
          btn_cnt[i] <= '0;
        end else if (btn_rise[i] || btn_fall[i]) begin
          btn_level[i] <= btn_sync_p1[i];
          btn_cnt[i]   <= '0;
        end else begin
          btn_cnt[i] <= sat_inc(btn_cnt[i], BTN_LAST);
        end
      end
    end
  end

  // Switch debounce: same rule as the buttons with its own terminal count.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) sw_cnt[i] <= '0;
      sw_stable <= '0;
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (sw_sync_p1[i] == sw_stable[i]) begin
          sw_cnt[i] <= '0;
        end else if (sw_commit[i]) begin
          sw_stable[i] <= sw_sync_p1[i];
          sw_cnt[i]    <= '0;
        end else begin
          sw_cnt[i] <= sat_inc(sw_cnt[i], SW_LAST);
        end
      end
    end
  end

  // Press requests from idle buttons; lowest index evaluated first so center wins.
  always_comb begin
    btn_req   = '0;
    btn_grant = '0;
    for (int i = 0; i < 5; i++) begin
      btn_req[i] = btn_rise[i] && (btn_state[i] == ST_IDLE);
    end
    for (int i = 0; i < 5; i++) begin
      if (btn_req[i]) begin
        btn_grant    = '0;
        btn_grant[i] = 1'b1;
      end
    end
  end

  // Press FSM per button; losers of arbitration still move to HELD, no replay.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 5; i++) btn_state[i] <= ST_IDLE;
      btn_pulse <= '0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        case (btn_state[i])
          ST_IDLE: if (btn_req[i])  btn_state[i] <= ST_HELD;
          default: if (btn_fall[i]) btn_state[i] <= ST_IDLE;
        endcase
      end
      btn_pulse <= btn_grant;
    end
  end

  // Card decode registered one cycle behind sw_stable.
  always_ff @(posedge clk) begin
    if (reset) begin
      card_onehot <= 1'b0;
      card_idx    <= 4'hF;
    end else begin
      {card_onehot, card_idx} <= card_decode(sw_stable[8:0]);
    end
  end

endmodule
